// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Lowest enabled channel index; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] first_en(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask[NUM_CH-1-i]) begin
                r = SEL_W'(NUM_CH - 1 - i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Round-robin channel picker: next enabled index after cur, with wrap flag.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Search cur+1, cur+2, ... cur+4 (mod 4); cur itself is the last candidate.
    always_comb begin
        nxt   = cur;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = SEL_W'(32'(cur) + k);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer driving the select of a 4:1 mux, sampling Y per enabled channel
// and assembling a 4-bit frame. Optional macro SCAN_SYNC_EN adds a 2-flop
// synchroniser on y_in and extends the settle count to D+2.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [SEL_W-1:0]   s,
    output logic               busy,
    output logic               sample_valid,
    output logic [SEL_W-1:0]   sample_ch,
    output logic               sample_bit,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid
);

    localparam int CNT_W = DWELL_W + 1;

    state_t             state;
    logic [NUM_CH-1:0]  en_q;
    logic [NUM_CH-1:0]  shadow;
    logic [NUM_CH-1:0]  shadow_m;
    logic               single_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_eff;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   settle_last;
    logic [SEL_W-1:0]   nxt;
    logic               wrap;
    logic               y_cap;

    mux_scan_next_ch u_next (
        .cur  (s),
        .mask (en_q),
        .nxt  (nxt),
        .wrap (wrap)
    );

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

`ifdef SCAN_SYNC_EN
    logic y_meta;
    logic y_sync;

    // Two-flop synchroniser on the mux output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_meta <= 1'b0;
            y_sync <= 1'b0;
        end else begin
            y_meta <= y_in;
            y_sync <= y_meta;
        end
    end

    assign y_cap       = y_sync;
    assign settle_last = CNT_W'(dwell_q) + CNT_W'(1);
`else
    assign y_cap       = y_in;
    assign settle_last = CNT_W'(dwell_q) - CNT_W'(1);
`endif

    // Shadow with the bit being captured this cycle merged in.
    always_comb begin
        shadow_m    = shadow;
        shadow_m[s] = y_cap;
    end

    // Scan FSM, dwell counter, shadow register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_bit   <= 1'b0;
            frame        <= '0;
            frame_valid  <= 1'b0;
            cnt          <= '0;
            en_q         <= '0;
            shadow       <= '0;
            single_q     <= 1'b0;
            dwell_q      <= '0;
        end else begin
            sample_valid <= 1'b0;
            frame_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && (ch_en != '0)) begin
                        en_q     <= ch_en;
                        single_q <= single;
                        dwell_q  <= dwell_eff;
                        s        <= first_en(ch_en);
                        cnt      <= '0;
                        shadow   <= '0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        shadow <= '0;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == settle_last) begin
                        cnt          <= '0;
                        sample_bit   <= y_cap;
                        sample_ch    <= s;
                        sample_valid <= 1'b1;
                        if (wrap) begin
                            frame       <= shadow_m;
                            frame_valid <= 1'b1;
                            shadow      <= '0;
                            en_q        <= ch_en;
                            dwell_q     <= dwell_eff;
                            // The next frame starts from the freshly latched mask, so the
                            // restart index comes from first_en rather than the old-mask picker.
                            if (single_q || (ch_en == '0)) begin
                                state <= DONE;
                            end else begin
                                s <= first_en(ch_en);
                            end
                        end else begin
                            shadow[s] <= y_cap;
                            s         <= nxt;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    shadow <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
